// File: rtl/seg7_scan_4digit.sv
// Four-digit multiplexed seven-segment driver for a common-anode display.
// Incoming BCD values are staged in a shadow register and committed to the
// displayed copy only at frame boundaries, so a frame never mixes old and new digits.
module seg7_scan_4digit #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes render as a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  logic [15:0]      shadow_digits_r;
  logic [3:0]       shadow_dp_r;
  logic             pending_r;
  logic [15:0]      disp_digits_r;
  logic [3:0]       disp_dp_r;
  logic             boundary_d_r;
  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic             frame_done_r;

  logic             tick_s;
  logic             boundary_s;
  logic [3:0]       cur_digit_s;
  logic             lead_zero_s;
  logic             blank_s;
  logic [3:0]       an_nxt_s;
  logic [6:0]       seg_nxt_s;
  logic             dp_nxt_s;

  // Digit-period tick and frame boundary (tick while the last digit is active).
  always_comb begin
    tick_s     = (cnt_r == CNT_MAX);
    boundary_s = tick_s && (idx_r == 2'd3);
  end

  // Refresh counter and active digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      idx_r <= 2'd0;
    end else if (tick_s) begin
      cnt_r <= '0;
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Shadow capture; the last load before a boundary wins, and a boundary always clears pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_digits_r <= 16'h0000;
      shadow_dp_r     <= 4'b0000;
      pending_r       <= 1'b0;
    end else begin
      if (load) begin
        shadow_digits_r <= digits;
        shadow_dp_r     <= dp_en;
      end
      if (boundary_s) begin
        pending_r <= 1'b0;
      end else if (load) begin
        pending_r <= 1'b1;
      end
    end
  end

  // Commit to the displayed copy at the boundary; a same-cycle load bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_digits_r <= 16'h0000;
      disp_dp_r     <= 4'b0000;
    end else if (boundary_s && load) begin
      disp_digits_r <= digits;
      disp_dp_r     <= dp_en;
    end else if (boundary_s && pending_r) begin
      disp_digits_r <= shadow_digits_r;
      disp_dp_r     <= shadow_dp_r;
    end
  end

  // Select the active digit and decide whether it is a blanked leading zero.
  always_comb begin
    cur_digit_s = 4'd0;
    lead_zero_s = 1'b0;
    case (idx_r)
      2'd0: begin
        cur_digit_s = disp_digits_r[3:0];
        lead_zero_s = 1'b0;
      end
      2'd1: begin
        cur_digit_s = disp_digits_r[7:4];
        lead_zero_s = (disp_digits_r[15:4] == 12'h000);
      end
      2'd2: begin
        cur_digit_s = disp_digits_r[11:8];
        lead_zero_s = (disp_digits_r[15:8] == 8'h00);
      end
      2'd3: begin
        cur_digit_s = disp_digits_r[15:12];
        lead_zero_s = (disp_digits_r[15:12] == 4'h0);
      end
      default: begin
        cur_digit_s = 4'd0;
        lead_zero_s = 1'b0;
      end
    endcase
    blank_s = blank_lz && lead_zero_s;
    if (blank_s) begin
      an_nxt_s  = 4'b1111;
      seg_nxt_s = 7'b1111111;
      dp_nxt_s  = 1'b1;
    end else begin
      an_nxt_s  = ~(4'b0001 << idx_r);
      seg_nxt_s = bcd_to_seg(cur_digit_s);
      dp_nxt_s  = ~disp_dp_r[idx_r];
    end
  end

  // Output registers; frame_done is delayed so it lines up with digit 0 of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boundary_d_r <= 1'b0;
      frame_done_r <= 1'b0;
      an_r         <= 4'b1111;
      seg_r        <= 7'b1111111;
      dp_r         <= 1'b1;
    end else begin
      boundary_d_r <= boundary_s;
      frame_done_r <= boundary_d_r;
      an_r         <= an_nxt_s;
      seg_r        <= seg_nxt_s;
      dp_r         <= dp_nxt_s;
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_4digit.sv
// Scoreboard bench for seg7_scan_4digit with REFRESH_DIV=4.
// The reference model works from edge numbers since reset release: the active
// digit and frame position follow from arithmetic on the edge count, and the
// displayed value is the latest load whose commit boundary has passed.
module tb_seg7_scan_4digit;

  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_en = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  typedef struct {
    int          edge_n;
    logic [15:0] d;
    logic [3:0]  p;
  } ld_t;

  exp_t exp_q[$];
  ld_t  loads[$];
  int   k = 0;
  int   checks = 0;
  int   passed = 0;

  seg7_scan_4digit #(.REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits     (digits),
    .dp_en      (dp_en),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Displayed {dp_en, digits} after edge j: the newest load committed by then.
  function automatic logic [19:0] disp_at(input int j);
    logic [19:0] v;
    int best;
    int c;
    v    = 20'h00000;
    best = -1;
    foreach (loads[i]) begin
      c = ((loads[i].edge_n + FRAME - 1) / FRAME) * FRAME;
      if (c <= j && loads[i].edge_n > best) begin
        best = loads[i].edge_n;
        v    = {loads[i].p, loads[i].d};
      end
    end
    return v;
  endfunction

  // Expected outputs right after edge kk (kk >= 1) since reset release.
  function automatic exp_t expect_edge(input int kk, input logic blz);
    exp_t e;
    logic [19:0] v;
    int idx;
    int upper;
    int nib;
    idx   = ((kk - 1) / RD) % 4;
    v     = disp_at(kk - 1);
    upper = int'(v[15:0]) >> (4 * idx);
    nib   = upper % 16;
    e.fd  = (kk > 1) && (((kk - 1) % FRAME) == 0);
    if (blz && idx > 0 && upper == 0) begin
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
      e.dp  = 1'b1;
    end else begin
      e.an      = 4'b1111;
      e.an[idx] = 1'b0;
      e.seg     = SEG_TAB[nib];
      e.dp      = ~v[16 + idx];
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int n = 0; n < 4; n++) begin
      d[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end
    return d;
  endfunction

  // One clock: drive inputs, predict the output after the coming edge, advance.
  task automatic cyc(input logic ld, input logic [15:0] d, input logic [3:0] p);
    exp_t e;
    ld_t  r;
    load   = ld;
    digits = d;
    dp_en  = p;
    if (rst_n) begin
      k++;
      if (ld) begin
        r.edge_n = k;
        r.d      = d;
        r.p      = p;
        loads.push_back(r);
      end
      e = expect_edge(k, blank_lz);
    end else begin
      e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, fd: 1'b0};
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    k     = 0;
    loads.delete();
    repeat (n) cyc(1'b0, 16'($urandom), 4'($urandom));
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({an, seg, dp, frame_done} !== e) begin
          $display("FAIL out t=%0t k=%0d got an=%b seg=%b dp=%b fd=%b need an=%b seg=%b dp=%b fd=%b",
                   $time, k, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        end else begin
          passed++;
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int r;
    @(negedge clk);
    do_reset(3);
    idle(40);

    idle(5);
    cyc(1'b1, 16'h1234, 4'b0100);
    idle(40);

    blank_lz = 1'b1;
    cyc(1'b1, 16'h0007, 4'b0010);
    idle(36);
    blank_lz = 1'b0;
    idle(20);

    cyc(1'b1, 16'h1111, 4'b0000);
    idle(3);
    cyc(1'b1, 16'h2222, 4'b0000);
    idle(40);

    while (((k + 1) % FRAME) != 0) cyc(1'b0, 16'($urandom), 4'($urandom));
    cyc(1'b1, 16'h5555, 4'b1001);
    idle(20);

    cyc(1'b1, 16'hABC9, 4'b0001);
    idle(40);

    cyc(1'b1, 16'h8888, 4'b1111);
    idle(3);
    do_reset(2);
    idle(40);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r >= 95) blank_lz = ~blank_lz;
      if (r < 2) begin
        do_reset(2);
      end else if (r < 12) begin
        cyc(1'b1, rand_digits(), 4'($urandom));
      end else begin
        cyc(1'b0, rand_digits(), 4'($urandom));
      end
    end

    load = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain left=%0d need=0", exp_q.size());
    end else begin
      passed++;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
